// File: rtl/backlight_frame_controller.sv
// Global-dimming scheduler: tracks per-frame max of linear RGB, commits on vsync rise, sequences PWM duty updates.
// Latency: frame_max valid 2 cycles after the vsync rise, pwm_value/sync_pulse 3 cycles after. No backpressure.
// Define BKLIGHT_SLEW_LIMIT_EN to slew pwm_value by at most MAX_STEP per update instead of jumping to frame_max.
module backlight_frame_controller #(
   parameter int         DE_DELAY    = 2,
   parameter logic [9:0] MIN_LEVEL   = 10'd16,
   parameter logic [9:0] RESET_LEVEL = 10'h3FF,
   parameter int         UPDATE_DIV  = 1,
   parameter logic [9:0] MAX_STEP    = 10'd32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       de,
   input  logic       vsync,
   input  logic [9:0] r_lin,
   input  logic [9:0] g_lin,
   input  logic [9:0] b_lin,
   output logic [9:0] pwm_value,
   output logic       sync_pulse,
   output logic [9:0] frame_max,
   output logic       active
);
   typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, APPLY} state_t;

   localparam logic [7:0] DIV_LAST = 8'(UPDATE_DIV - 1);

   state_t     state, state_nxt;
   logic       vsync_prev, vs_rise, de_d, upd;
   logic       acc_clr, snap_ld, commit_en, apply_en;
   logic [9:0] acc, snap, rg_max, px, next_pwm;
   logic [7:0] div_cnt;

   assign vs_rise = vsync & ~vsync_prev;
   assign rg_max  = (r_lin > g_lin) ? r_lin : g_lin;
   assign px      = (rg_max > b_lin) ? rg_max : b_lin;
   assign active  = (state != IDLE);

   // de is realigned to the gamma ROM output by matching its read latency
   generate
      if (DE_DELAY == 0) begin : g_de_direct
         assign de_d = de;
      end else begin : g_de_pipe
         logic [DE_DELAY-1:0] de_pipe;
         always_ff @(posedge clk) begin
            if (reset) begin
               de_pipe <= '0;
            end else begin
               de_pipe[0] <= de;
               for (int i = 1; i < DE_DELAY; i++) de_pipe[i] <= de_pipe[i-1];
            end
         end
         assign de_d = de_pipe[DE_DELAY-1];
      end
   endgenerate

`ifdef BKLIGHT_SLEW_LIMIT_EN
   logic [10:0] diff, step;
   logic        rising;
   always_comb begin
      rising   = (frame_max >= pwm_value);
      diff     = rising ? ({1'b0, frame_max} - {1'b0, pwm_value})
                        : ({1'b0, pwm_value} - {1'b0, frame_max});
      step     = (diff > {1'b0, MAX_STEP}) ? {1'b0, MAX_STEP} : diff;
      next_pwm = rising ? 10'({1'b0, pwm_value} + step) : 10'({1'b0, pwm_value} - step);
   end
`else
   logic unused_max_step;
   assign unused_max_step = ^MAX_STEP;
   assign next_pwm        = frame_max;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // dropping enable aborts any commit/apply in flight; all held outputs stay put
   always_comb begin
      state_nxt = state;
      acc_clr   = 1'b0;
      snap_ld   = 1'b0;
      commit_en = 1'b0;
      apply_en  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (vs_rise) begin
               state_nxt = ACCUM;
               acc_clr   = 1'b1;
            end
            ACCUM: if (vs_rise) begin
               state_nxt = COMMIT;
               snap_ld   = 1'b1;
               acc_clr   = 1'b1;
            end
            COMMIT: begin
               state_nxt = APPLY;
               commit_en = 1'b1;
            end
            APPLY: begin
               state_nxt = ACCUM;
               apply_en  = upd;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_prev <= 1'b0;
         acc        <= '0;
         snap       <= '0;
         div_cnt    <= '0;
         upd        <= 1'b0;
         frame_max  <= '0;
         pwm_value  <= RESET_LEVEL;
         sync_pulse <= 1'b0;
      end else begin
         vsync_prev <= vsync;
         sync_pulse <= apply_en;
         // the pixel coincident with the vsync rise lands in snap, later ones in the fresh acc
         if (acc_clr)
            acc <= '0;
         else if (de_d && (state != IDLE) && (px > acc))
            acc <= px;
         if (snap_ld)
            snap <= (de_d && (px > acc)) ? px : acc;
         if (commit_en) begin
            frame_max <= (snap > MIN_LEVEL) ? snap : MIN_LEVEL;
            if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               upd     <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 8'd1;
               upd     <= 1'b0;
            end
         end
         if (apply_en)
            pwm_value <= next_pwm;
      end
   end
endmodule

// File: tb/tb_backlight_frame_controller.sv
// Directed bench for backlight_frame_controller: one instance with UPDATE_DIV=1, one with UPDATE_DIV=3.
`timescale 1ns/1ps
module tb_backlight_frame_controller;
`ifdef BKLIGHT_SLEW_LIMIT_EN
   localparam bit SLEW = 1'b1;
`else
   localparam bit SLEW = 1'b0;
`endif
   localparam logic [9:0] J = 10'd1011;

   typedef struct {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
      logic [9:0] exp_fm;
      logic [9:0] exp_pwm;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, enable, de, vsync;
   logic [9:0] r_lin, g_lin, b_lin;
   logic [9:0] pwm_value, frame_max, pwm_value3, frame_max3;
   logic       sync_pulse, active, sync_pulse3, active3;

   int         n_pass  = 0;
   int         n_total = 0;
   int         commit3;
   logic [9:0] pwm_m, pwm3_m;
   vec_t       vecs[12];

   always #5 clk = ~clk;

   backlight_frame_controller dut (
      .clk(clk), .reset(reset), .enable(enable), .de(de), .vsync(vsync),
      .r_lin(r_lin), .g_lin(g_lin), .b_lin(b_lin),
      .pwm_value(pwm_value), .sync_pulse(sync_pulse), .frame_max(frame_max), .active(active)
   );

   backlight_frame_controller #(.UPDATE_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .enable(enable), .de(de), .vsync(vsync),
      .r_lin(r_lin), .g_lin(g_lin), .b_lin(b_lin),
      .pwm_value(pwm_value3), .sync_pulse(sync_pulse3), .frame_max(frame_max3), .active(active3)
   );

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic cyc(input logic d, input logic v, input logic [9:0] r, input logic [9:0] g,
                      input logic [9:0] b);
      de = d; vsync = v; r_lin = r; g_lin = g; b_lin = b;
      @(posedge clk); #1;
   endtask

   function automatic logic [9:0] model_next(input logic [9:0] cur, input logic [9:0] fm);
      int d;
      if (!SLEW) return fm;
      d = (fm > cur) ? int'(fm) - int'(cur) : int'(cur) - int'(fm);
      if (d > 32) d = 32;
      return (fm > cur) ? 10'(int'(cur) + d) : 10'(int'(cur) - d);
   endfunction

   // junk (J) sits where de_d is low, so any misaligned de delay picks it up
   task automatic frame(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, J, J, J);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, r, g, b);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, r, g, b);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, J, J, J);
      cyc(1'b0, 1'b1, J, J, J);
   endtask

   task automatic chk_fm(input logic [9:0] fm);
      check("frame_max", frame_max, fm);
      check("frame_max_div3", frame_max3, fm);
   endtask

   task automatic chk_apply(input logic [9:0] fm, input logic [9:0] exp_pwm);
      pwm_m = SLEW ? model_next(pwm_m, fm) : exp_pwm;
      commit3++;
      if (commit3 % 3 == 0) pwm3_m = model_next(pwm3_m, fm);
      check("sync_pulse", sync_pulse, 1);
      check("pwm_value", pwm_value, pwm_m);
      check("sync_pulse_div3", sync_pulse3, (commit3 % 3 == 0) ? 1 : 0);
      check("pwm_value_div3", pwm_value3, pwm3_m);
   endtask

   task automatic chk_quiet();
      check("sync_pulse_width", sync_pulse, 0);
      check("sync_pulse_width_div3", sync_pulse3, 0);
      check("active", active, 1);
   endtask

   task automatic post_commit(input logic [9:0] fm, input logic [9:0] exp_pwm);
      cyc(1'b0, 1'b1, J, J, J); chk_fm(fm);
      cyc(1'b0, 1'b1, J, J, J); chk_apply(fm, exp_pwm);
      cyc(1'b0, 1'b1, J, J, J); chk_quiet();
   endtask

   task automatic chk_reset();
      check("rst_pwm_value", pwm_value, 10'h3FF);
      check("rst_frame_max", frame_max, 0);
      check("rst_sync_pulse", sync_pulse, 0);
      check("rst_active", active, 0);
      check("rst_pwm_value_div3", pwm_value3, 10'h3FF);
      pwm_m = 10'h3FF; pwm3_m = 10'h3FF; commit3 = 0;
   endtask

   initial begin
      vecs[0]  = '{10'd600, 10'd100,  10'd200, 10'd600,  10'd600};
      vecs[1]  = '{10'd100, 10'd600,  10'd50,  10'd600,  10'd600};
      vecs[2]  = '{10'd5,   10'd3,    10'd0,   10'd16,   10'd16};
      vecs[3]  = '{10'd0,   10'd0,    10'd15,  10'd16,   10'd16};
      vecs[4]  = '{10'd16,  10'd0,    10'd0,   10'd16,   10'd16};
      vecs[5]  = '{10'd17,  10'd2,    10'd3,   10'd17,   10'd17};
      vecs[6]  = '{10'd3,   10'd1023, 10'd9,   10'd1023, 10'd1023};
      vecs[7]  = '{10'd700, 10'd800,  10'd900, 10'd900,  10'd900};
      vecs[8]  = '{10'd0,   10'd0,    10'd0,   10'd16,   10'd16};
      vecs[9]  = '{10'd512, 10'd511,  10'd513, 10'd513,  10'd513};
      vecs[10] = '{10'd600, 10'd600,  10'd600, 10'd600,  10'd600};
      vecs[11] = '{10'd1,   10'd1,    10'd1,   10'd16,   10'd16};

      reset = 1'b1; enable = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
      reset = 1'b0;
      chk_reset();

      // vsync rise while disabled stays in IDLE
      enable = 1'b0;
      cyc(1'b0, 1'b1, J, J, J); check("idle_no_enable", active, 0);
      cyc(1'b0, 1'b0, J, J, J);
      enable = 1'b1;

      // first rise only leaves IDLE; its partial frame (900) is discarded
      frame(10'd900, 10'd900, 10'd900);
      check("leave_idle", active, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, J, J, J);
         check("first_rise_no_pulse", sync_pulse, 0);
      end
      check("first_rise_fm", frame_max, 0);
      check("first_rise_pwm", pwm_value, 10'h3FF);

      // constant px=100 from full backlight: direct jump, or 32-step slew down to 100
      for (int k = 0; k < 30; k++) begin
         frame(10'd100, 10'd40, 10'd70);
         post_commit(10'd100, 10'd100);
      end

      foreach (vecs[i]) begin
         frame(vecs[i].r, vecs[i].g, vecs[i].b);
         post_commit(vecs[i].exp_fm, vecs[i].exp_pwm);
      end

      // de alignment plus vsync glitch during APPLY
      cyc(1'b1, 1'b0, J, J, J);
      cyc(1'b1, 1'b0, J, J, J);
      cyc(1'b1, 1'b0, 10'd200, 10'd10, 10'd10);
      cyc(1'b1, 1'b0, 10'd10, 10'd250, 10'd10);
      cyc(1'b1, 1'b1, 10'd10, 10'd10, 10'd260);
      cyc(1'b0, 1'b0, 10'd900, 10'd10, 10'd10); chk_fm(10'd260);
      cyc(1'b0, 1'b1, 10'd10, 10'd10, 10'd10);  chk_apply(10'd260, 10'd260);
      cyc(1'b0, 1'b1, J, J, J); chk_quiet();
      cyc(1'b0, 1'b1, J, J, J);
      check("glitch_single_commit", frame_max, 10'd260);
      check("glitch_no_pulse", sync_pulse, 0);
      cyc(1'b0, 1'b0, J, J, J);
      cyc(1'b0, 1'b1, J, J, J);
      post_commit(10'd900, 10'd900);

      // enable dropped during COMMIT aborts the update
      frame(10'd500, 10'd0, 10'd0);
      enable = 1'b0;
      cyc(1'b0, 1'b1, J, J, J);
      check("abort_idle", active, 0);
      check("abort_idle_div3", active3, 0);
      check("abort_fm_hold", frame_max, 10'd900);
      cyc(1'b0, 1'b1, J, J, J);
      check("abort_no_pulse", sync_pulse, 0);
      check("abort_no_pulse_div3", sync_pulse3, 0);
      check("abort_pwm_hold", pwm_value, pwm_m);
      check("abort_pwm_hold_div3", pwm_value3, pwm3_m);
      cyc(1'b0, 1'b0, J, J, J);
      cyc(1'b0, 1'b1, J, J, J);
      check("disabled_rise_ignored", active, 0);
      enable = 1'b1;
      frame(10'd700, 10'd0, 10'd0);
      check("reenter_accum", active, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, J, J, J);
         check("reenter_no_pulse", sync_pulse, 0);
      end
      check("reenter_fm_hold", frame_max, 10'd900);
      frame(10'd300, 10'd0, 10'd0);
      post_commit(10'd300, 10'd300);

      // reset mid-frame
      cyc(1'b1, 1'b0, J, J, J);
      cyc(1'b1, 1'b0, J, J, J);
      cyc(1'b1, 1'b0, 10'd800, 10'd0, 10'd0);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 10'd800, 10'd0, 10'd0);
      reset = 1'b0;
      chk_reset();
      frame(10'd800, 10'd0, 10'd0);
      check("post_reset_leave_idle", active, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, J, J, J);
         check("post_reset_no_pulse", sync_pulse, 0);
      end
      frame(10'd40, 10'd0, 10'd0);
      post_commit(10'd40, 10'd40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
